// File: rtl/ad7606_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad7606_emu_pkg
//  Brief    : Shared constants, state encodings and helpers for ad7606_emu.
//  Revision : 1.0 - initial release
// ============================================================================
package ad7606_emu_pkg;

    localparam int c_num_ch      = 8;
    localparam int c_data_w      = 16;
    localparam int c_frame_w     = 13;
    localparam int c_ch_w        = 3;
    localparam int c_cnt_w       = 24;
    localparam int c_rst_cnt_w   = 8;
    localparam int c_t_delay     = 2;
    localparam int c_conv_cycles = 200;
    localparam int c_rst_cycles  = 3;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_conv = 2'd2;
    localparam logic [1:0] c_st_rst  = 2'd3;

    typedef logic [c_frame_w-1:0] frame_t;

    // Oversampling code 7 is reserved on the real part and behaves as no oversampling.
    function automatic logic [2:0] os_effective(input logic [2:0] os);
        return (os == 3'd7) ? 3'd0 : os;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad7606_emu.sv
`default_nettype none
// ============================================================================
//  Module   : ad7606_emu
//  Brief    : Cycle-level AD7606 responder producing busy timing and a
//             deterministic {channel, frame} sample pattern on the read port.
//  Revision : 1.0 - initial release
// ============================================================================
module ad7606_emu
    import ad7606_emu_pkg::*;
#(
    parameter int NUM_CH      = c_num_ch,
    parameter int DATA_W      = c_data_w,
    parameter int T_DELAY     = c_t_delay,
    parameter int CONV_CYCLES = c_conv_cycles,
    parameter int RST_CYCLES  = c_rst_cycles
) (
    input  logic                 clk_50_0,
    input  logic                 reset_syn,
    input  logic [2:0]           ad_os,
    input  logic                 ad_cs,
    input  logic                 ad_rd,
    input  logic                 ad_reset,
    input  logic                 ad_convstab,
    output logic [DATA_W-1:0]    ad_data,
    output logic                 ad_busy,
    output logic                 first_data,
    output logic [c_frame_w-1:0] frame_cnt,
    output logic                 overrun_err
);

    logic [1:0]             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_os;
    logic [c_rst_cnt_w-1:0] r_rst_cnt;
    logic                   r_convst_q;
    logic                   r_rd_q;
    logic [c_ch_w-1:0]      r_ch_idx;
    logic [DATA_W-1:0]      r_ad_data;
    logic                   r_busy;
    logic                   r_first;
    frame_t                 r_frame_cnt;
    logic                   r_overrun;

    logic                   w_convst_rise;
    logic                   w_rd_fall;
    logic [DATA_W-1:0]      w_sample;
    logic [c_cnt_w-1:0]     w_conv_len;
    logic [c_ch_w-1:0]      w_ch_next;
    logic                   w_rst_valid;

    assign w_convst_rise = ad_convstab & ~r_convst_q;
    assign w_rd_fall     = ~ad_rd & r_rd_q;
    assign w_sample      = DATA_W'({r_ch_idx, r_frame_cnt});
    assign w_conv_len    = (c_cnt_w'(CONV_CYCLES) << r_os) - c_cnt_w'(1);
    assign w_ch_next     = (r_ch_idx == c_ch_w'(NUM_CH - 1)) ? '0 : r_ch_idx + c_ch_w'(1);
    assign w_rst_valid   = (r_rst_cnt >= c_rst_cnt_w'(RST_CYCLES));

    always_ff @(posedge clk_50_0 or negedge reset_syn) begin
        if (!reset_syn) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_os        <= '0;
            r_rst_cnt   <= '0;
            r_convst_q  <= 1'b0;
            r_rd_q      <= 1'b1;
            r_ch_idx    <= '0;
            r_ad_data   <= '0;
            r_busy      <= 1'b0;
            r_first     <= 1'b0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_convst_q <= ad_convstab;
            r_rd_q     <= ad_rd;

            if (ad_reset) begin
                r_state <= c_st_rst;
                r_busy  <= 1'b0;
                if (r_state != c_st_rst) begin
                    r_rst_cnt <= c_rst_cnt_w'(1);
                end else if (!w_rst_valid) begin
                    r_rst_cnt <= r_rst_cnt + c_rst_cnt_w'(1);
                end
            end else begin
                // Read port runs ahead of the FSM so an end-of-conversion ch_idx clear wins.
                if (r_state != c_st_rst) begin
                    if (ad_cs) begin
                        r_ad_data <= '0;
                        r_first   <= 1'b0;
                    end else if (w_rd_fall) begin
                        r_ad_data <= w_sample;
                        r_first   <= (r_ch_idx == '0);
                        r_ch_idx  <= w_ch_next;
                    end
                end

                case (r_state)
                    c_st_idle: begin
                        if (w_convst_rise) begin
                            r_state <= c_st_wait;
                            r_cnt   <= c_cnt_w'(T_DELAY - 1);
                            r_os    <= os_effective(ad_os);
                        end
                    end
                    c_st_wait: begin
                        if (w_convst_rise) begin
                            r_overrun <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_state <= c_st_conv;
                            r_busy  <= 1'b1;
                            r_cnt   <= w_conv_len;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_w'(1);
                        end
                    end
                    c_st_conv: begin
                        if (w_convst_rise) begin
                            r_overrun <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_state     <= c_st_idle;
                            r_busy      <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + frame_t'(1);
                            r_ch_idx    <= '0;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_w'(1);
                        end
                    end
                    default: begin
                        // A pulse too short to count only aborts; counters survive.
                        r_state <= c_st_idle;
                        if (w_rst_valid) begin
                            r_frame_cnt <= '0;
                            r_ch_idx    <= '0;
                            r_overrun   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign ad_data     = r_ad_data;
    assign ad_busy     = r_busy;
    assign first_data  = r_first;
    assign frame_cnt   = r_frame_cnt;
    assign overrun_err = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ad7606_emu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad7606_emu
//  Brief    : Self-checking bench for ad7606_emu: directed tables plus random
//             conversions/reads compared against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ad7606_emu;

    logic        clk_50_0 = 1'b0;
    logic        reset_syn;
    logic [2:0]  ad_os;
    logic        ad_cs;
    logic        ad_rd;
    logic        ad_reset;
    logic        ad_convstab;
    logic [15:0] ad_data;
    logic        ad_busy;
    logic        first_data;
    logic [12:0] frame_cnt;
    logic        overrun_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        cs;
        logic [15:0] exp_data;
        logic        exp_first;
    } rd_vec_t;

    rd_vec_t vecs [12];

    ad7606_emu dut (
        .clk_50_0    (clk_50_0),
        .reset_syn   (reset_syn),
        .ad_os       (ad_os),
        .ad_cs       (ad_cs),
        .ad_rd       (ad_rd),
        .ad_reset    (ad_reset),
        .ad_convstab (ad_convstab),
        .ad_data     (ad_data),
        .ad_busy     (ad_busy),
        .first_data  (first_data),
        .frame_cnt   (frame_cnt),
        .overrun_err (overrun_err)
    );

    always #10 clk_50_0 = ~clk_50_0;

    task automatic tick();
        @(posedge clk_50_0);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic cs, output logic [15:0] d, output logic f);
        ad_cs = cs;
        tick();
        ad_rd = 1'b0;
        tick();
        tick();
        d = ad_data;
        f = first_data;
        ad_rd = 1'b1;
        tick();
    endtask

    task automatic run_conv(input logic [2:0] os, input int repulse_at, output int dly, output int len);
        ad_os = os;
        ad_convstab = 1'b1;
        len = 0;
        tick();
        ad_convstab = 1'b0;
        dly = 1;
        while (!ad_busy && dly < 50) begin
            tick();
            dly++;
        end
        while (ad_busy && len < 20000) begin
            ad_convstab = (len == repulse_at);
            tick();
            len++;
        end
        ad_convstab = 1'b0;
    endtask

    task automatic rst_pulse(input int n);
        ad_reset = 1'b1;
        repeat (n) tick();
        ad_reset = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int          dly;
        int          len;
        int          exp_len;
        int          m_frame;
        int          m_ch;
        int          sel;
        int          nrd;
        int          rl;
        logic [2:0]  os;
        logic        cs;
        logic [15:0] d;
        logic        f;
        logic [15:0] exp_d;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b0, {i[2:0], 13'd1}, (i == 0)};
        end
        vecs[8]  = '{1'b0, 16'h0001, 1'b1};
        vecs[9]  = '{1'b1, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 16'h2001, 1'b0};

        reset_syn   = 1'b0;
        ad_os       = 3'd0;
        ad_cs       = 1'b1;
        ad_rd       = 1'b1;
        ad_reset    = 1'b0;
        ad_convstab = 1'b0;
        repeat (3) tick();
        reset_syn = 1'b1;
        tick();
        chk("reset_data", 32'(ad_data), 32'h0);
        chk("reset_busy", 32'(ad_busy), 32'h0);
        chk("reset_first", 32'(first_data), 32'h0);
        chk("reset_frame", 32'(frame_cnt), 32'h0);
        chk("reset_overrun", 32'(overrun_err), 32'h0);

        // os=0 baseline conversion
        run_conv(3'd0, -1, dly, len);
        chk("os0_delay", dly, 3);
        chk("os0_len", len, 200);
        chk("os0_frame", 32'(frame_cnt), 32'd1);

        // Nine reads wrap back to ch0, then cs=1 reads are ignored
        for (int i = 0; i < 12; i++) begin
            do_read(vecs[i].cs, d, f);
            chk($sformatf("tbl_data[%0d]", i), 32'(d), 32'(vecs[i].exp_data));
            chk($sformatf("tbl_first[%0d]", i), 32'(f), 32'(vecs[i].exp_first));
        end

        run_conv(3'd2, -1, dly, len);
        chk("os2_len", len, 800);
        run_conv(3'd7, -1, dly, len);
        chk("os7_len", len, 200);
        chk("os7_frame", 32'(frame_cnt), 32'd3);

        // cs=1 reads leave ch_idx at 0, so the next cs=0 read returns ch0
        do_read(1'b1, d, f);
        chk("cs1_data", 32'(d), 32'h0);
        do_read(1'b1, d, f);
        chk("cs1_data2", 32'(d), 32'h0);
        do_read(1'b0, d, f);
        chk("cs0_after_cs1_data", 32'(d), 32'h0003);
        chk("cs0_after_cs1_first", 32'(f), 32'h1);

        // Re-pulsed convst while busy
        run_conv(3'd0, 50, dly, len);
        chk("overrun_len", len, 200);
        chk("overrun_flag", 32'(overrun_err), 32'h1);
        chk("overrun_frame", 32'(frame_cnt), 32'd4);
        rst_pulse(2);
        chk("short_rst_frame", 32'(frame_cnt), 32'd4);
        chk("short_rst_overrun", 32'(overrun_err), 32'h1);
        rst_pulse(3);
        chk("valid_rst_frame", 32'(frame_cnt), 32'd0);
        chk("valid_rst_overrun", 32'(overrun_err), 32'h0);

        // Short device reset mid-conversion aborts without a frame increment
        ad_os = 3'd0;
        ad_convstab = 1'b1;
        tick();
        ad_convstab = 1'b0;
        repeat (20) tick();
        chk("abort_busy_before", 32'(ad_busy), 32'h1);
        rst_pulse(2);
        chk("abort_busy_after", 32'(ad_busy), 32'h0);
        repeat (300) tick();
        chk("abort_busy_later", 32'(ad_busy), 32'h0);
        chk("abort_frame", 32'(frame_cnt), 32'd0);

        // Randomized conversions, reads and device resets against the model
        m_frame = 0;
        m_ch    = 0;
        for (int it = 0; it < 8; it++) begin
            sel = $urandom_range(0, 4);
            os  = (sel == 4) ? 3'd7 : sel[2:0];
            run_conv(os, -1, dly, len);
            m_frame = (m_frame + 1) % 8192;
            m_ch    = 0;
            exp_len = 200 << ((os == 3'd7) ? 0 : int'(os));
            chk("rnd_delay", dly, 3);
            chk("rnd_len", len, exp_len);
            chk("rnd_frame", 32'(frame_cnt), 32'(m_frame));
            nrd = $urandom_range(1, 12);
            for (int j = 0; j < nrd; j++) begin
                cs = ($urandom_range(0, 3) == 0);
                do_read(cs, d, f);
                if (cs) begin
                    chk("rnd_cs1_data", 32'(d), 32'h0);
                    chk("rnd_cs1_first", 32'(f), 32'h0);
                end else begin
                    exp_d = {m_ch[2:0], m_frame[12:0]};
                    chk("rnd_data", 32'(d), 32'(exp_d));
                    chk("rnd_first", 32'(f), 32'(m_ch == 0));
                    m_ch = (m_ch + 1) % 8;
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                rl = $urandom_range(1, 4);
                rst_pulse(rl);
                if (rl >= 3) begin
                    m_frame = 0;
                    m_ch    = 0;
                end
                chk("rnd_rst_frame", 32'(frame_cnt), 32'(m_frame));
            end
            chk("rnd_overrun", 32'(overrun_err), 32'h0);
        end

        // Asynchronous system reset in the middle of a conversion
        run_conv(3'd0, -1, dly, len);
        do_read(1'b0, d, f);
        ad_convstab = 1'b1;
        tick();
        ad_convstab = 1'b0;
        repeat (30) tick();
        chk("async_busy_before", 32'(ad_busy), 32'h1);
        #4;
        reset_syn = 1'b0;
        #1;
        chk("async_busy", 32'(ad_busy), 32'h0);
        chk("async_data", 32'(ad_data), 32'h0);
        chk("async_frame", 32'(frame_cnt), 32'h0);
        chk("async_first", 32'(first_data), 32'h0);
        tick();
        reset_syn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
